mdu_hilo: RTL

Iterative multiply/divide unit with the architectural HI/LO registers. It sits directly downstream of the register file read ports: operands come from `rd1`/`rd2`, a MULT/MULTU/DIV/DIVU issue starts a fixed-latency operation, and the results land in HI/LO for later MFHI/MFLO. It stalls the front end via `busy`.

---
 rtl/mdu_hilo.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/mdu_hilo.sv
// mdu_hilo: iterative 32-cycle multiply/divide unit that owns the architectural HI/LO registers.
// Define MDU_DIV_EN to build the restoring divider (DIV/DIVU); without it only MULT/MULTU are issued.
module mdu_hilo #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wd,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;
    logic [WIDTH-1:0]   opb_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic [WIDTH-1:0]   hi_d;
    logic [WIDTH-1:0]   lo_d;
    logic               negq_q;
    logic               done_q;

    logic               is_signed;
    logic               accept;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod;
`ifdef MDU_DIV_EN
    logic               is_div_q;
    logic               negr_q;
    logic               dz_q;
    logic [WIDTH:0]     div_sh;
    logic [WIDTH:0]     div_diff;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
`endif

    // acc_q holds {partial, multiplier} for MULT and {remainder, dividend/quotient} for DIV.
    always_comb begin
        is_signed = ~op[0];
        abs_a     = (is_signed && a[WIDTH-1]) ? -a : a;
        abs_b     = (is_signed && b[WIDTH-1]) ? -b : b;
`ifdef MDU_DIV_EN
        accept    = start;
`else
        accept    = start && !op[1];
`endif
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        acc_d     = {mul_sum, acc_q[WIDTH-1:1]};
        prod      = negq_q ? -acc_q : acc_q;
        hi_d      = prod[2*WIDTH-1:WIDTH];
        lo_d      = prod[WIDTH-1:0];
`ifdef MDU_DIV_EN
        div_sh    = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff  = div_sh - {1'b0, opb_q};
        quo       = acc_q[WIDTH-1:0];
        rem       = acc_q[2*WIDTH-1:WIDTH];
        if (is_div_q) begin
            acc_d = {(div_diff[WIDTH] ? div_sh[WIDTH-1:0] : div_diff[WIDTH-1:0]),
                     acc_q[WIDTH-2:0], ~div_diff[WIDTH]};
            // With a zero divisor the remainder path shifts |a| through unchanged, so the
            // sign fix already restores the original a for HI; only LO needs the override.
            hi_d  = negr_q ? -rem : rem;
            lo_d  = dz_q ? '1 : (negq_q ? -quo : quo);
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            negq_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
`ifdef MDU_DIV_EN
            is_div_q <= 1'b0;
            negr_q   <= 1'b0;
            dz_q     <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (hi_we) hi_q <= wd;
                    if (lo_we) lo_q <= wd;
                    if (accept) begin
                        state_q  <= RUN;
                        cnt_q    <= '0;
                        acc_q    <= {{WIDTH{1'b0}}, abs_a};
                        opb_q    <= abs_b;
                        negq_q   <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
`ifdef MDU_DIV_EN
                        is_div_q <= op[1];
                        negr_q   <= is_signed & a[WIDTH-1];
                        dz_q     <= (b == '0);
`endif
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) state_q <= FIN;
                end
                FIN: begin
                    hi_q    <= hi_d;
                    lo_q    <= lo_d;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
